spi_slave_ctrl: RTL

//  Serial front end of the SPI-slave/single-port-RAM wrapper; sits directly upstream of the RAM.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_shift_cnt.sv | 38 +++
 rtl/spi_slave_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-slave/RAM wrapper: frame geometry, RAM command
// codes carried in din[9:8], and the front-end FSM state set.
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_shift_cnt.sv
// Load/shift register paired with a down-counter of bits still to move.
// It shifts only while bits remain, so it goes quiet once a frame or byte is done.
module spi_shift_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         din,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         last
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (load) begin
      q   <= load_val;
      cnt <= CW'(W);
    end else if (shift && busy) begin
      q   <= {q[W-2:0], din};
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CW'(1));

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames toward the RAM and serialises
// RAM read data back onto MISO. One FSM, one clock, synchronous reset.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W = SPI_FRAME_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic               MISO,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_CHK_CMD   = CHK_CMD;
  localparam logic [2:0] ST_WRITE     = WRITE;
  localparam logic [2:0] ST_READ_ADD  = READ_ADD;
  localparam logic [2:0] ST_READ_DATA = READ_DATA;

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic               rd_addr_seen;

  logic               rx_clr, rx_load, rx_shift, rx_busy, rx_last, rx_complete;
  logic [FRAME_W-1:0] rx_q;
  logic               tx_clr, tx_shift, tx_latch, tx_busy, tx_last;
  logic [DATA_W-1:0]  tx_q;
  logic               in_rx_state;

  assign in_rx_state = (state == ST_WRITE) || (state == ST_READ_ADD) || (state == ST_READ_DATA);

  // Counters are armed on the command edge; deselect or IDLE wipes any partial frame.
  assign rx_clr      = SS_n || (state == ST_IDLE);
  assign rx_load     = (state == ST_CHK_CMD);
  assign rx_shift    = in_rx_state && !SS_n;
  assign rx_complete = rx_shift && rx_last;

  // Wait phase: frame done and the rx_valid cycle already past, so the RAM has had time to answer.
  assign tx_latch = (state == ST_READ_DATA) && !SS_n && !rx_busy && !rx_valid &&
                    rd_addr_seen && tx_valid;
  assign tx_clr   = SS_n || (state != ST_READ_DATA);
  assign tx_shift = (state == ST_READ_DATA) && !SS_n;

  spi_shift_cnt #(.W(FRAME_W)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .clr      (rx_clr),
    .load     (rx_load),
    .load_val ('0),
    .shift    (rx_shift),
    .din      (MOSI),
    .q        (rx_q),
    .busy     (rx_busy),
    .last     (rx_last)
  );

  spi_shift_cnt #(.W(DATA_W)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .clr      (tx_clr),
    .load     (tx_latch),
    .load_val (tx_data),
    .shift    (tx_shift),
    .din      (1'b0),
    .q        (tx_q),
    .busy     (tx_busy),
    .last     (tx_last)
  );

  // The RX MSB is superseded by the incoming bit; the TX side only exposes its MSB.
  logic unused_bits;
  assign unused_bits = ^{rx_q[FRAME_W-1], tx_q[DATA_W-2:0], tx_last};

  always_comb begin
    next_state = state;
    if (state != ST_IDLE && SS_n) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (!SS_n) next_state = ST_CHK_CMD;
        ST_CHK_CMD:   next_state = !MOSI ? ST_WRITE : (rd_addr_seen ? ST_READ_DATA : ST_READ_ADD);
        ST_WRITE,
        ST_READ_ADD,
        ST_READ_DATA: next_state = state;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
    end else begin
      state    <= next_state;
      rx_valid <= rx_complete;
      MISO     <= tx_shift && tx_busy && tx_q[DATA_W-1];
      if (rx_complete) begin
        rx_data <= {rx_q[FRAME_W-2:0], MOSI};
      end
      if (state == ST_READ_ADD && rx_complete) begin
        rd_addr_seen <= 1'b1;
      end else if (tx_latch) begin
        rd_addr_seen <= 1'b0;
      end
    end
  end

endmodule
